// File: rtl/pong_pkg.sv
// Shared types and default geometry for the ball engine.
// Pure declarations, no logic.
// No flow control.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_e;

  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_BALL_SIZE   = 8;
  localparam int DEF_PADDLE_W    = 8;
  localparam int DEF_PADDLE_H    = 64;
  localparam int DEF_PADDLE_L_X  = 16;
  localparam int DEF_PADDLE_R_X  = 616;
  localparam int DEF_BALL_SPEED  = 2;
  localparam int DEF_WIN_SCORE   = 9;
  localparam int DEF_SERVE_DELAY = 60;

  // Top-left corner that places the ball in the middle of a span.
  function automatic logic [10:0] centre(input int span, input int ball);
    return 11'((span - ball) / 2);
  endfunction

  localparam logic [10:0] CENTRE_X = centre(DEF_SCREEN_W, DEF_BALL_SIZE);
  localparam logic [10:0] CENTRE_Y = centre(DEF_SCREEN_H, DEF_BALL_SIZE);

endpackage

// File: rtl/pong_ball_engine_if.sv
// Frame-tick input, paddle positions and renderer-facing ball/score outputs.
// No latency of its own.
// No flow control; outputs are level signals.
interface pong_ball_engine_if;
  logic        EOD;
  logic        start;
  logic [10:0] paddle_l_y;
  logic [10:0] paddle_r_y;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        game_over;
  logic [2:0]  state;

  modport master (
    output EOD, start, paddle_l_y, paddle_r_y,
    input  ball_x, ball_y, score_l, score_r, game_over, state
  );

  modport slave (
    input  EOD, start, paddle_l_y, paddle_r_y,
    output ball_x, ball_y, score_l, score_r, game_over, state
  );
endinterface

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on the end-of-display flag: one tick per frame.
// Tick is combinational in the cycle EOD first goes high.
// No flow control; a long EOD level still yields one tick.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic eod,
  output logic tick
);

  logic eod_q;

  // Remember last cycle's EOD so only the 0->1 transition fires.
  always_ff @(posedge clk) begin
    if (rst) eod_q <= 1'b0;
    else     eod_q <= eod;
  end

  assign tick = eod & ~eod_q;

endmodule

// File: rtl/pong_ball_engine.sv
// Per-frame ball motion, collisions, scoring and serve/play/game-over control.
// All registers move on the frame tick; outputs show the result 1 clk later.
// No flow control; the tick is accepted unconditionally.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int BALL_SIZE   = DEF_BALL_SIZE,
  parameter int PADDLE_W    = DEF_PADDLE_W,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int PADDLE_L_X  = DEF_PADDLE_L_X,
  parameter int PADDLE_R_X  = DEF_PADDLE_R_X,
  parameter int BALL_SPEED  = DEF_BALL_SPEED,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SERVE_DELAY = DEF_SERVE_DELAY
) (
  input  logic               clk,
  input  logic               rst,
  pong_ball_engine_if.slave  bus
);

  localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  // Geometry in 12-bit so sums past the screen edge never wrap.
  localparam logic [11:0] W     = 12'(SCREEN_W);
  localparam logic [11:0] H     = 12'(SCREEN_H);
  localparam logic [11:0] SZ    = 12'(BALL_SIZE);
  localparam logic [11:0] SPD   = 12'(BALL_SPEED);
  localparam logic [11:0] PH    = 12'(PADDLE_H);
  localparam logic [11:0] R_X   = 12'(PADDLE_R_X);
  localparam logic [11:0] L_FC  = 12'(PADDLE_L_X + PADDLE_W);
  localparam logic [11:0] CTR_X = {1'b0, centre(SCREEN_W, BALL_SIZE)};
  localparam logic [11:0] CTR_Y = {1'b0, centre(SCREEN_H, BALL_SIZE)};
  localparam logic [3:0]  WIN   = 4'(WIN_SCORE);
  localparam logic [CW-1:0] RELOAD = CW'(SERVE_DELAY - 1);

  logic tick;

  frame_tick_gen u_tick (
    .clk  (clk),
    .rst  (rst),
    .eod  (bus.EOD),
    .tick (tick)
  );

  state_e        st_q, st_n;
  logic [10:0]   bx_q, by_q;
  logic [11:0]   bx_n, by_n, bx, by, pl, pr;
  logic          dxr_q, dxr_n;   // 1 = moving right
  logic          dyd_q, dyd_n;   // 1 = moving down
  logic [3:0]    sl_q, sl_n, sr_q, sr_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          ovl_l, ovl_r;

  assign bx = {1'b0, bx_q};
  assign by = {1'b0, by_q};
  assign pl = {1'b0, bus.paddle_l_y};
  assign pr = {1'b0, bus.paddle_r_y};

  assign ovl_l = (by + SZ > pl) && (by < pl + PH);
  assign ovl_r = (by + SZ > pr) && (by < pr + PH);

  // Next frame's state, ball and scores; only committed on a tick.
  always_comb begin
    st_n  = st_q;
    bx_n  = bx;
    by_n  = by;
    dxr_n = dxr_q;
    dyd_n = dyd_q;
    sl_n  = sl_q;
    sr_n  = sr_q;
    cnt_n = cnt_q;
    unique case (st_q)
      ST_IDLE: begin
        bx_n = CTR_X;
        by_n = CTR_Y;
        if (bus.start) begin
          st_n  = ST_SERVE;
          cnt_n = RELOAD;
        end
      end
      ST_SERVE: begin
        bx_n = CTR_X;
        by_n = CTR_Y;
        if (cnt_q == '0) st_n = ST_PLAY;
        else             cnt_n = cnt_q - 1'b1;
      end
      ST_PLAY: begin
        if (!dyd_q) begin
          if (by < SPD) begin
            by_n  = '0;
            dyd_n = 1'b1;
          end else begin
            by_n = by - SPD;
          end
        end else if (by + SZ + SPD > H) begin
          by_n  = H - SZ;
          dyd_n = 1'b0;
        end else begin
          by_n = by + SPD;
        end

        // A miss freezes the ball and sets the next serve direction:
        // a right-side miss serves leftward, a left-side miss rightward.
        if (dxr_q) begin
          if ((bx + SZ <= R_X) && (bx + SZ + SPD > R_X) && ovl_r) begin
            bx_n  = R_X - SZ;
            dxr_n = 1'b0;
          end else if (bx + SZ + SPD > W) begin
            bx_n  = bx;
            by_n  = by;
            dxr_n = 1'b0;
            sl_n  = (sl_q == WIN) ? WIN : sl_q + 1'b1;
            st_n  = ST_POINT;
          end else begin
            bx_n = bx + SPD;
          end
        end else begin
          if ((bx >= L_FC) && (bx < L_FC + SPD) && ovl_l) begin
            bx_n  = L_FC;
            dxr_n = 1'b1;
          end else if (bx < SPD) begin
            bx_n  = bx;
            by_n  = by;
            dxr_n = 1'b1;
            sr_n  = (sr_q == WIN) ? WIN : sr_q + 1'b1;
            st_n  = ST_POINT;
          end else begin
            bx_n = bx - SPD;
          end
        end
      end
      ST_POINT: begin
        bx_n  = CTR_X;
        by_n  = CTR_Y;
        dyd_n = 1'b1;
        if (sl_q == WIN || sr_q == WIN) begin
          st_n = ST_GAMEOVER;
        end else begin
          st_n  = ST_SERVE;
          cnt_n = RELOAD;
        end
      end
      ST_GAMEOVER: begin
        bx_n = CTR_X;
        by_n = CTR_Y;
        if (bus.start) begin
          st_n = ST_IDLE;
          sl_n = '0;
          sr_n = '0;
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  // Game state register: reset wins, otherwise advance once per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      bx_q  <= CTR_X[10:0];
      by_q  <= CTR_Y[10:0];
      dxr_q <= 1'b1;
      dyd_q <= 1'b1;
      sl_q  <= '0;
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (tick) begin
      st_q  <= st_n;
      bx_q  <= bx_n[10:0];
      by_q  <= by_n[10:0];
      dxr_q <= dxr_n;
      dyd_q <= dyd_n;
      sl_q  <= sl_n;
      sr_q  <= sr_n;
      cnt_q <= cnt_n;
    end
  end

  assign bus.ball_x    = bx_q;
  assign bus.ball_y    = by_q;
  assign bus.score_l   = sl_q;
  assign bus.score_r   = sr_q;
  assign bus.game_over = (st_q == ST_GAMEOVER);
  assign bus.state     = st_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for the ball engine with hand-computed expectations.
// Checks land on the falling edge after each frame tick.
// Drives EOD as short pulses or long levels to exercise the edge detector.
module tb_pong_ball_engine;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pong_ball_engine_if bus ();

  pong_ball_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    bus.EOD = 1'b1;
    @(negedge clk);
    bus.EOD = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold_eod(input int n);
    @(negedge clk);
    bus.EOD = 1'b1;
    repeat (n) @(negedge clk);
    bus.EOD = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.EOD        = 1'b0;
    bus.start      = 1'b0;
    bus.paddle_l_y = 11'd1000;
    bus.paddle_r_y = 11'd400;

    do_reset();
    check("rst_x", bus.ball_x, 316);
    check("rst_y", bus.ball_y, 236);
    check("rst_sl", bus.score_l, 0);
    check("rst_sr", bus.score_r, 0);
    check("rst_go", bus.game_over, 0);
    check("rst_st", bus.state, ST_IDLE);

    // Long EOD with no start: remains idle at centre.
    hold_eod(800);
    check("idle_st", bus.state, ST_IDLE);
    check("idle_x", bus.ball_x, 316);

    // Long EOD with start: a single tick, so exactly 60 more to PLAY.
    bus.start = 1'b1;
    hold_eod(800);
    bus.start = 1'b0;
    check("serve_st", bus.state, ST_SERVE);
    ticks(59);
    check("serve59_st", bus.state, ST_SERVE);
    tick();
    check("play_st", bus.state, ST_PLAY);
    check("play0_x", bus.ball_x, 316);

    ticks(118);
    check("t118_x", bus.ball_x, 552);
    check("t118_y", bus.ball_y, 472);
    tick();
    check("t119_x", bus.ball_x, 554);
    check("t119_y", bus.ball_y, 472);
    ticks(27);
    check("t146_x", bus.ball_x, 608);
    check("t146_y", bus.ball_y, 418);
    tick();
    check("t147_x", bus.ball_x, 608);
    check("t147_y", bus.ball_y, 416);
    tick();
    check("t148_x", bus.ball_x, 606);
    check("t148_y", bus.ball_y, 414);

    // Same trajectory, right paddle parked at the top: a miss.
    do_reset();
    bus.paddle_r_y = 11'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ticks(60);
    check("p2_play", bus.state, ST_PLAY);
    ticks(158);
    check("t158_x", bus.ball_x, 632);
    check("t158_y", bus.ball_y, 394);
    tick();
    check("miss_st", bus.state, ST_POINT);
    check("miss_x", bus.ball_x, 632);
    check("miss_sl", bus.score_l, 1);
    check("miss_sr", bus.score_r, 0);
    tick();
    check("pt_st", bus.state, ST_SERVE);
    check("pt_x", bus.ball_x, 316);
    check("pt_y", bus.ball_y, 236);
    ticks(60);
    check("rs_play", bus.state, ST_PLAY);
    tick();
    check("rs_x", bus.ball_x, 314);
    check("rs_y", bus.ball_y, 238);

    // Left paddle tracks the ball, right paddle out of reach: left scores.
    bus.paddle_r_y = 11'd1000;
    for (int p = 2; p <= 9; p++) begin
      for (int t = 0; t < 2000 && bus.state != ST_POINT; t++) begin
        bus.paddle_l_y = bus.ball_y;
        tick();
      end
      check($sformatf("point%0d_st", p), bus.state, ST_POINT);
      check($sformatf("point%0d_sl", p), bus.score_l, p);
      check($sformatf("point%0d_sr", p), bus.score_r, 0);
      if (p < 9) tick();
    end
    tick();
    check("go_st", bus.state, ST_GAMEOVER);
    check("go_flag", bus.game_over, 1);
    check("go_sl", bus.score_l, 9);
    check("go_x", bus.ball_x, 316);
    tick();
    check("go_hold", bus.state, ST_GAMEOVER);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_st", bus.state, ST_IDLE);
    check("restart_sl", bus.score_l, 0);
    check("restart_go", bus.game_over, 0);

    // Reset arriving together with a tick in the middle of play.
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ticks(60 + 42);
    check("mid_x", bus.ball_x, 400);
    check("mid_y", bus.ball_y, 320);
    @(negedge clk);
    rst = 1'b1;
    bus.EOD = 1'b1;
    @(negedge clk);
    check("mrst_x", bus.ball_x, 316);
    check("mrst_y", bus.ball_y, 236);
    check("mrst_st", bus.state, ST_IDLE);
    check("mrst_sl", bus.score_l, 0);
    check("mrst_go", bus.game_over, 0);
    rst = 1'b0;
    bus.EOD = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
